// File: rtl/march_bist_ctrl.sv
// March-test BIST controller (March C-, March LR, MATS+) for single-port synchronous SRAM.
// Define BIST_DIAG_EN to add the fail_syn / fail_elem first-miscompare diagnostic outputs.
module march_bist_ctrl #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 4,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en_in,
   input  logic [1:0]        mode_in,
   input  logic [DATA_W-1:0] dat_in,
   output logic [DATA_W-1:0] dat_out,
   output logic [ADDR_W-1:0] addr_out,
   output logic              w_en_out,
   output logic              rst_done,
   output logic              fail,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [CNT_W-1:0]  fail_cnt
`ifdef BIST_DIAG_EN
   ,
   output logic [DATA_W-1:0] fail_syn,
   output logic [2:0]        fail_elem
`endif
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   // Per-element descriptor; bit i of wr/val describes op i at one address.
   typedef struct packed {
      logic [1:0] last_op;
      logic       down;
      logic [3:0] wr;
      logic [3:0] val;
   } elem_t;

   function automatic elem_t elem_info(input logic [1:0] mode, input logic [2:0] elem);
      elem_t e;
      e = '0;
      case (mode)
         2'd1: case (elem)
            3'd0:    e = {2'd0, 1'b0, 4'b0001, 4'b0000};
            3'd1:    e = {2'd1, 1'b1, 4'b0010, 4'b0010};
            3'd2:    e = {2'd3, 1'b0, 4'b1010, 4'b1001};
            3'd3:    e = {2'd1, 1'b0, 4'b0010, 4'b0001};
            3'd4:    e = {2'd3, 1'b0, 4'b1010, 4'b0110};
            3'd5:    e = {2'd0, 1'b0, 4'b0000, 4'b0000};
            default: e = '0;
         endcase
         2'd2: case (elem)
            3'd0:    e = {2'd0, 1'b0, 4'b0001, 4'b0000};
            3'd1:    e = {2'd1, 1'b0, 4'b0010, 4'b0010};
            3'd2:    e = {2'd1, 1'b1, 4'b0010, 4'b0001};
            default: e = '0;
         endcase
         default: case (elem)
            3'd0:    e = {2'd0, 1'b0, 4'b0001, 4'b0000};
            3'd1:    e = {2'd1, 1'b0, 4'b0010, 4'b0010};
            3'd2:    e = {2'd1, 1'b0, 4'b0010, 4'b0001};
            3'd3:    e = {2'd1, 1'b1, 4'b0010, 4'b0010};
            3'd4:    e = {2'd1, 1'b1, 4'b0010, 4'b0001};
            3'd5:    e = {2'd0, 1'b0, 4'b0000, 4'b0000};
            default: e = '0;
         endcase
      endcase
      return e;
   endfunction

   function automatic logic elem_down(input logic [1:0] mode, input logic [2:0] elem);
      elem_t e;
      e = elem_info(mode, elem);
      return e.down;
   endfunction

   state_t              state_q, state_d;
   logic [1:0]          mode_q, mode_d;
   logic [2:0]          elem_q, elem_d;
   logic [1:0]          op_q, op_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                pv_q, pv_d;
   logic                pexp_q, pexp_d;
   logic [ADDR_W-1:0]   paddr_q, paddr_d;
   logic                fail_q, fail_d;
   logic [ADDR_W-1:0]   fail_addr_q, fail_addr_d;
   logic [CNT_W-1:0]    fail_cnt_q, fail_cnt_d;
`ifdef BIST_DIAG_EN
   logic [2:0]          pelem_q, pelem_d;
   logic [DATA_W-1:0]   fail_syn_q, fail_syn_d;
   logic [2:0]          fail_elem_q, fail_elem_d;
`endif

   elem_t               cur;
   logic                op_wr, op_val, last_op, term, last_elem, mismatch;

   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      elem_d      = elem_q;
      op_d        = op_q;
      addr_d      = addr_q;
      pv_d        = 1'b0;
      pexp_d      = pexp_q;
      paddr_d     = paddr_q;
      fail_d      = fail_q;
      fail_addr_d = fail_addr_q;
      fail_cnt_d  = fail_cnt_q;
`ifdef BIST_DIAG_EN
      pelem_d     = pelem_q;
      fail_syn_d  = fail_syn_q;
      fail_elem_d = fail_elem_q;
`endif
      w_en_out    = 1'b0;
      addr_out    = '0;
      dat_out     = '0;

      cur       = elem_info(mode_q, elem_q);
      op_wr     = cur.wr[op_q];
      op_val    = cur.val[op_q];
      last_op   = (op_q == cur.last_op);
      term      = cur.down ? (addr_q == '0) : (addr_q == '1);
      last_elem = (elem_q == ((mode_q == 2'd2) ? 3'd2 : 3'd5));
      mismatch  = pv_q && (dat_in != {DATA_W{pexp_q}});

      case (state_q)
         IDLE: begin
            if (en_in) begin
               state_d     = RUN;
               mode_d      = (mode_in == 2'd3) ? 2'd0 : mode_in;
               elem_d      = '0;
               op_d        = '0;
               addr_d      = '0;
               fail_d      = 1'b0;
               fail_addr_d = '0;
               fail_cnt_d  = '0;
`ifdef BIST_DIAG_EN
               fail_syn_d  = '0;
               fail_elem_d = '0;
`endif
            end
         end
         RUN: begin
            w_en_out = op_wr;
            addr_out = addr_q;
            dat_out  = {DATA_W{op_val}};
            if (!en_in) begin
               state_d = IDLE;
               elem_d  = '0;
               op_d    = '0;
               addr_d  = '0;
            end else begin
               pv_d    = !op_wr;
               pexp_d  = op_val;
               paddr_d = addr_q;
`ifdef BIST_DIAG_EN
               pelem_d = elem_q;
`endif
               if (!last_op) begin
                  op_d = op_q + 2'd1;
               end else begin
                  op_d = '0;
                  if (!term) begin
                     addr_d = cur.down ? addr_q - ADDR_W'(1) : addr_q + ADDR_W'(1);
                  end else if (last_elem) begin
                     state_d = DRAIN;
                     elem_d  = '0;
                     addr_d  = '0;
                  end else begin
                     // New element: reload the address for its own direction in the same cycle.
                     elem_d = elem_q + 3'd1;
                     addr_d = elem_down(mode_q, elem_q + 3'd1) ? '1 : '0;
                  end
               end
            end
         end
         DRAIN: state_d = en_in ? DONE : IDLE;
         DONE:  if (!en_in) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // The compare stage is independent of the FSM so a final or aborted read is still recorded.
      if (mismatch) begin
         fail_d = 1'b1;
         if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + CNT_W'(1);
         if (!fail_q) begin
            fail_addr_d = paddr_q;
`ifdef BIST_DIAG_EN
            fail_syn_d  = dat_in ^ {DATA_W{pexp_q}};
            fail_elem_d = pelem_q;
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         mode_q      <= '0;
         elem_q      <= '0;
         op_q        <= '0;
         addr_q      <= '0;
         pv_q        <= 1'b0;
         pexp_q      <= 1'b0;
         paddr_q     <= '0;
         fail_q      <= 1'b0;
         fail_addr_q <= '0;
         fail_cnt_q  <= '0;
`ifdef BIST_DIAG_EN
         pelem_q     <= '0;
         fail_syn_q  <= '0;
         fail_elem_q <= '0;
`endif
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         elem_q      <= elem_d;
         op_q        <= op_d;
         addr_q      <= addr_d;
         pv_q        <= pv_d;
         pexp_q      <= pexp_d;
         paddr_q     <= paddr_d;
         fail_q      <= fail_d;
         fail_addr_q <= fail_addr_d;
         fail_cnt_q  <= fail_cnt_d;
`ifdef BIST_DIAG_EN
         pelem_q     <= pelem_d;
         fail_syn_q  <= fail_syn_d;
         fail_elem_q <= fail_elem_d;
`endif
      end
   end

   assign rst_done  = (state_q == DONE);
   assign fail      = fail_q;
   assign fail_addr = fail_addr_q;
   assign fail_cnt  = fail_cnt_q;
`ifdef BIST_DIAG_EN
   assign fail_syn  = fail_syn_q;
   assign fail_elem = fail_elem_q;
`endif

endmodule
